wb_stage: RTL
=============

# wb_stage

Write-back stage of the five-stage ARM pipeline and the sole writer of the register file's write port. Holds the MEM/WB pipeline register, selects between the ALU result and load data, and drives `destWB`/`resultWB`/`writeBackEn`. Writes to R15 are diverted to a PC redirect, since the register file holds only R0–R14. It also exports a forwarding tap for the hazard/forwarding unit and a retired-instruction counter.

## Interface
Parameters:
- `WIDTH`, 32, datapath width.
- `CNT_WIDTH`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `validMEM`  in  1  MEM stage holds a real instruction.
- `wbEnMEM`  in  1  instruction writes a register.
- `memREnMEM`  in  1  instruction is a load; the result comes from memory data.
- `aluResMEM`  in  WIDTH  ALU result / address.
- `memDataMEM`  in  WIDTH  load data from the memory stage.
- `destMEM`  in  4  destination register number.
- `freeze`  in  1  memory stall; hold the MEM/WB register.
- `flush`  in  1  squash the MEM/WB register contents.
- `writeBackEn`  out  1  register-file write enable.
- `destWB`  out  4  register-file write address.
- `resultWB`  out  WIDTH  register-file write data.
- `pcWrEn`  out  1  R15 write; redirect fetch.
- `pcWrAddr`  out  WIDTH  redirect target.
- `fwdEn`  out  1  forwarding tap valid.
- `fwdDest`  out  4  forwarding tap register number.
- `fwdVal`  out  WIDTH  forwarding tap value.
- `retired`  out  CNT_WIDTH  count of valid instructions that left WB.

## Operation
- MEM/WB register fields: `v`, `wbEn`, `memREn`, `aluRes`, `memData`, `dest`.
- Update priority on each rising edge:
  - `flush=1`: `v`←0; other fields don't-care. Flush wins over freeze.
  - else `freeze=1`: all fields hold.
  - else: all fields load from the MEM inputs.
- Result select: `res = memREn ? memData : aluRes`.
- Outputs are combinational from the registered state only; no input-to-output paths.
  - `destWB = dest`, `resultWB = res`.
  - `writeBackEn = v & wbEn & (dest != 15)`.
  - `pcWrEn = v & wbEn & (dest == 15)`, `pcWrAddr = res`.
  - `fwdEn = writeBackEn`, `fwdDest = dest`, `fwdVal = res`. R15 is never forwarded.
- Retire counter:
  - Increments by 1 on each rising edge where `v=1` and `freeze=0`, i.e. the instruction leaves WB.
  - A frozen instruction is counted exactly once.
  - A valid instruction overwritten by `flush` is still counted: it was in WB and wrote back.
  - Wraps modulo 2^CNT_WIDTH.

## Timing
- Latency: MEM inputs sampled at rising edge N appear on the outputs after edge N.
- The register file commits on the following falling edge, which gives write-before-read within the same cycle.
- During `freeze`, `writeBackEn` stays asserted for every frozen cycle with identical dest/data. Repeated writes are idempotent and allowed.
- `pcWrEn` is a level. The fetch unit must treat a frozen repeat as the same redirect.
- Reset (`rst=0`, asynchronous): `v`, `wbEn`, `memREn` ← 0; `aluRes`, `memData` ← 0; `dest` ← 0; `retired` ← 0.
  - Hence all outputs are 0 while `rst=0`, including `writeBackEn`, `pcWrEn` and `fwdEn`.
  - Reset asserted mid-freeze discards the held instruction, which is not counted.
- Deassertion of `rst` is synchronised externally; the first capture happens on the first rising edge with `rst=1`.

## Structure
- Shared pipeline package:
  - `REG_PC = 4'd15`.
  - `NUM_GPR = 15`.
  - The MEM/WB bundle typedef (v, wbEn, memREn, aluRes, memData, dest), reused by the MEM stage outputs.
- One natural sub-module, `wb_pipe_reg`: the generic MEM/WB register with async active-low reset, freeze and flush.
- The result mux, R15 decode and counter live in `wb_stage`.

## Test plan
- **Reset:** hold `rst=0` with random inputs → all outputs 0, `retired=0`. Release, drive an ALU write (dest=3, aluRes=0x1234) → next cycle `writeBackEn=1`, `destWB=3`, `resultWB=0x1234`, `retired` increments to 1 on the following edge.
- **Load select:** `memREnMEM=1`, aluRes=0x100, memData=0xDEADBEEF, dest=7 → `resultWB=0xDEADBEEF`, `fwdVal=0xDEADBEEF`, `fwdDest=7`.
- **R15 redirect:** `wbEnMEM=1`, dest=15, aluRes=0x80 → `pcWrEn=1`, `pcWrAddr=0x80`, `writeBackEn=0`, `fwdEn=0`.
- **Freeze:** capture dest=2/0x55, then `freeze=1` for 3 cycles while inputs change → outputs hold dest=2/0x55 and `writeBackEn=1` throughout. After release, `retired` has grown by exactly 1 for that instruction.
- **Flush vs freeze:** assert `flush=1` and `freeze=1` together with a valid instruction held → next cycle `v=0` (all enables 0), held instruction counted once.
- **Reset mid-operation:** pull `rst=0` asynchronously between edges while frozen → outputs drop to 0 immediately, `retired=0`.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared pipeline definitions: register numbering and the MEM/WB bundle.
package wb_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned NUM_GPR = 15;
  localparam logic [REG_W-1:0] REG_PC = 4'd15;

  // MEM-stage output bundle at the default datapath width.
  typedef struct packed {
    logic             v;
    logic             wbEn;
    logic             memREn;
    logic [XLEN-1:0]  aluRes;
    logic [XLEN-1:0]  memData;
    logic [REG_W-1:0] dest;
  } mem_wb_t;

endpackage

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register with async active-low reset, freeze and flush.
module wb_pipe_reg
  import wb_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             vNext,
  input  logic             wbEnNext,
  input  logic             memREnNext,
  input  logic [WIDTH-1:0] aluResNext,
  input  logic [WIDTH-1:0] memDataNext,
  input  logic [REG_W-1:0] destNext,
  output logic             v,
  output logic             wbEn,
  output logic             memREn,
  output logic [WIDTH-1:0] aluRes,
  output logic [WIDTH-1:0] memData,
  output logic [REG_W-1:0] dest
);

  // Flush only clears the valid bit; payload fields are don't-care and simply hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v       <= 1'b0;
      wbEn    <= 1'b0;
      memREn  <= 1'b0;
      aluRes  <= '0;
      memData <= '0;
      dest    <= '0;
    end else if (flush) begin
      v       <= 1'b0;
    end else if (!freeze) begin
      v       <= vNext;
      wbEn    <= wbEnNext;
      memREn  <= memREnNext;
      aluRes  <= aluResNext;
      memData <= memDataNext;
      dest    <= destNext;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: result select, R15 redirect, forwarding tap and retire counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 validMEM,
  input  logic                 wbEnMEM,
  input  logic                 memREnMEM,
  input  logic [WIDTH-1:0]     aluResMEM,
  input  logic [WIDTH-1:0]     memDataMEM,
  input  logic [REG_W-1:0]     destMEM,
  input  logic                 freeze,
  input  logic                 flush,
  output logic                 writeBackEn,
  output logic [REG_W-1:0]     destWB,
  output logic [WIDTH-1:0]     resultWB,
  output logic                 pcWrEn,
  output logic [WIDTH-1:0]     pcWrAddr,
  output logic                 fwdEn,
  output logic [REG_W-1:0]     fwdDest,
  output logic [WIDTH-1:0]     fwdVal,
  output logic [CNT_WIDTH-1:0] retired
);

  logic             v;
  logic             wbEn;
  logic             memREn;
  logic [WIDTH-1:0] aluRes;
  logic [WIDTH-1:0] memData;
  logic [REG_W-1:0] dest;
  logic [WIDTH-1:0] res;
  logic             isPc;
  logic             leaving;

  wb_pipe_reg #(.WIDTH(WIDTH)) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .flush      (flush),
    .vNext      (validMEM),
    .wbEnNext   (wbEnMEM),
    .memREnNext (memREnMEM),
    .aluResNext (aluResMEM),
    .memDataNext(memDataMEM),
    .destNext   (destMEM),
    .v          (v),
    .wbEn       (wbEn),
    .memREn     (memREn),
    .aluRes     (aluRes),
    .memData    (memData),
    .dest       (dest)
  );

  assign res         = memREn ? memData : aluRes;
  assign isPc        = (dest == REG_PC);
  assign writeBackEn = v & wbEn & ~isPc;
  assign destWB      = dest;
  assign resultWB    = res;
  assign pcWrEn      = v & wbEn & isPc;
  assign pcWrAddr    = res;
  assign fwdEn       = writeBackEn;
  assign fwdDest     = dest;
  assign fwdVal      = res;

  // An instruction leaves WB when it is not held, or when a flush displaces it.
  assign leaving = v & (~freeze | flush);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired <= '0;
    end else if (leaving) begin
      retired <= retired + CNT_WIDTH'(1);
    end
  end

endmodule
